// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and line-geometry helpers for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IC_BURST = 2'd1,
        DC_BURST = 2'd2
    } state_t;

    // Which cache owned the most recent burst, used for round-robin tie breaks
    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    // Line offset bits for the default 4-word line (word index + byte offset)
    localparam int DEFAULT_LINE_WORDS = 4;
    localparam int LINE_OFF_BITS      = $clog2(DEFAULT_LINE_WORDS) + 2;

    // Line offset bits for an arbitrary power-of-two line size
    function automatic int line_off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_burst_seq.sv
// Beat sequencer for one cache-line burst: holds the line base, counts beats,
// produces the word address of the current beat and flags the final beat.
module mem_burst_seq
    import mem_port_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              advance,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              last_beat
);

    localparam int OFF_W  = line_off_bits(LINE_WORDS);
    localparam int BEAT_W = $clog2(LINE_WORDS);

    logic [BEAT_W-1:0]       beat;
    logic [ADDR_W-OFF_W-1:0] line;
    logic                    unused_low;

    // The byte/word offset of the miss address is discarded; every burst starts at word 0
    assign unused_low = ^start_addr[OFF_W-1:0];

    // Beat counter: restarts on a new grant, wraps naturally after the last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if (start) begin
            beat <= '0;
        end else if (advance) begin
            beat <= beat + BEAT_W'(1);
        end
    end

    // Line base capture; only meaningful while a burst is active, so it carries no reset
    always_ff @(posedge clk) begin
        if (start) begin
            line <= start_addr[ADDR_W-1:OFF_W];
        end
    end

    assign beat_addr = {line, OFF_W'(0)} + ADDR_W'({beat, 2'b00});
    assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between Icache refills and Dcache refills/write-backs.
// Round-robin arbitration in IDLE, fixed-length bursts, and a drop flag that lets the
// fetch side abandon a refill while the memory transaction still runs to completion.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic              ic_abort_i,
    output logic              ic_gnt_o,
    output logic [31:0]       ic_rdata_o,
    output logic              ic_rvalid_o,
    output logic              ic_done_o,

    input  logic              dc_req_i,
    input  logic              dc_we_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [31:0]       dc_wdata_i,
    output logic              dc_gnt_o,
    output logic              dc_wnext_o,
    output logic [31:0]       dc_rdata_o,
    output logic              dc_rvalid_o,
    output logic              dc_done_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i
);

    state_t            state;
    state_t            state_nxt;
    owner_t            last_owner;
    logic              drop;
    logic              we;

    logic              ic_cand;
    logic              dc_cand;
    logic              grant_ic;
    logic              grant_dc;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              in_burst;
    logic              ic_own;
    logic              dc_own;
    logic              beat_done;
    logic              last_beat;
    logic              last_done;
    logic [ADDR_W-1:0] beat_addr;

    // An abort in IDLE masks the Icache request for that cycle only
    assign ic_cand    = ic_req_i && !ic_abort_i;
    assign dc_cand    = dc_req_i;

    assign in_burst   = (state != IDLE);
    assign ic_own     = (state == IC_BURST);
    assign dc_own     = (state == DC_BURST);
    assign beat_done  = in_burst && mem_ready_i;
    assign last_done  = beat_done && last_beat;

    assign start      = grant_ic || grant_dc;
    assign start_addr = grant_ic ? ic_addr_i : dc_addr_i;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decode; ties go to the side that did not own the last burst
    always_comb begin
        state_nxt = state;
        grant_ic  = 1'b0;
        grant_dc  = 1'b0;
        case (state)
            IDLE: begin
                if (ic_cand && (!dc_cand || last_owner == OWN_DC)) begin
                    grant_ic  = 1'b1;
                    state_nxt = IC_BURST;
                end else if (dc_cand) begin
                    grant_dc  = 1'b1;
                    state_nxt = DC_BURST;
                end
            end
            IC_BURST, DC_BURST: begin
                if (last_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Burst direction latched at grant; Icache bursts are always reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we <= 1'b0;
        end else if (start) begin
            we <= grant_dc && dc_we_i;
        end
    end

    // Round-robin history, updated when a burst finishes its last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWN_DC;
        end else if (last_done) begin
            last_owner <= ic_own ? OWN_IC : OWN_DC;
        end
    end

    // Drop flag: an abort during an Icache burst silences the rest of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop <= 1'b0;
        end else if (last_done) begin
            drop <= 1'b0;
        end else if (ic_own && ic_abort_i) begin
            drop <= 1'b1;
        end
    end

    mem_burst_seq #(
        .LINE_WORDS (LINE_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .advance    (beat_done),
        .beat_addr  (beat_addr),
        .last_beat  (last_beat)
    );

    // Memory port: everything is qualified by the burst state so IDLE drives zeros
    assign mem_req_o   = in_burst;
    assign mem_we_o    = in_burst && we;
    assign mem_addr_o  = in_burst ? beat_addr : '0;
    assign mem_wdata_o = (dc_own && we) ? dc_wdata_i : '0;

    // Icache response steering
    assign ic_gnt_o    = ic_own;
    assign ic_rvalid_o = ic_own && mem_ready_i && !drop;
    assign ic_rdata_o  = ic_rvalid_o ? mem_rdata_i : '0;
    assign ic_done_o   = ic_own && last_done && !drop;

    // Dcache response steering
    assign dc_gnt_o    = dc_own;
    assign dc_rvalid_o = dc_own && mem_ready_i && !we;
    assign dc_wnext_o  = dc_own && mem_ready_i && we;
    assign dc_rdata_o  = dc_rvalid_o ? mem_rdata_i : '0;
    assign dc_done_o   = dc_own && last_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter. Inputs change on the falling
// edge and outputs are sampled 1 time unit later, well away from the rising edge.
module tb_mem_port_arbiter;

    localparam int AW = 32;

    // Expected control bits: {req, we, ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_wnext, dc_rvalid, dc_done}
    localparam logic [8:0] C_IDLE = 9'b000000000;
    localparam logic [8:0] C_ICW  = 9'b101000000;
    localparam logic [8:0] C_ICV  = 9'b101100000;
    localparam logic [8:0] C_ICD  = 9'b101110000;
    localparam logic [8:0] C_DWW  = 9'b110001100;
    localparam logic [8:0] C_DWD  = 9'b110001101;
    localparam logic [8:0] C_DRV  = 9'b100001010;
    localparam logic [8:0] C_DRD  = 9'b100001011;

    typedef struct {
        logic          rst;
        logic          icr;
        logic [AW-1:0] ica;
        logic          iab;
        logic          dcr;
        logic          dwe;
        logic [AW-1:0] dca;
        logic [31:0]   dwd;
        logic          rdy;
        logic [AW-1:0] eaddr;
        logic [8:0]    ectl;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req_i, ic_abort_i, ic_gnt_o, ic_rvalid_o, ic_done_o;
    logic [AW-1:0] ic_addr_i;
    logic [31:0]   ic_rdata_o;
    logic          dc_req_i, dc_we_i, dc_gnt_o, dc_wnext_o, dc_rvalid_o, dc_done_o;
    logic [AW-1:0] dc_addr_i;
    logic [31:0]   dc_wdata_i, dc_rdata_o;
    logic          mem_req_o, mem_we_o, mem_ready_i;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o, mem_rdata_i;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.LINE_WORDS(4), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ic_req_i    (ic_req_i),
        .ic_addr_i   (ic_addr_i),
        .ic_abort_i  (ic_abort_i),
        .ic_gnt_o    (ic_gnt_o),
        .ic_rdata_o  (ic_rdata_o),
        .ic_rvalid_o (ic_rvalid_o),
        .ic_done_o   (ic_done_o),
        .dc_req_i    (dc_req_i),
        .dc_we_i     (dc_we_i),
        .dc_addr_i   (dc_addr_i),
        .dc_wdata_i  (dc_wdata_i),
        .dc_gnt_o    (dc_gnt_o),
        .dc_wnext_o  (dc_wnext_o),
        .dc_rdata_o  (dc_rdata_o),
        .dc_rvalid_o (dc_rvalid_o),
        .dc_done_o   (dc_done_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i)
    );

    function automatic vec_t mk(input logic r, input logic icr, input logic [AW-1:0] ica,
                                input logic iab, input logic dcr, input logic dwe,
                                input logic [AW-1:0] dca, input logic [31:0] dwd,
                                input logic rdy, input logic [AW-1:0] eaddr,
                                input logic [8:0] ectl);
        vec_t v;
        v.rst = r;   v.icr = icr; v.ica = ica; v.iab = iab;
        v.dcr = dcr; v.dwe = dwe; v.dca = dca; v.dwd = dwd;
        v.rdy = rdy; v.eaddr = eaddr; v.ectl = ectl;
        return v;
    endfunction

    function automatic logic [8:0] ctl_now();
        return {mem_req_o, mem_we_o, ic_gnt_o, ic_rvalid_o, ic_done_o,
                dc_gnt_o, dc_wnext_o, dc_rvalid_o, dc_done_o};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        ic_req_i = 1'b0; ic_addr_i = '0; ic_abort_i = 1'b0;
        dc_req_i = 1'b0; dc_we_i = 1'b0; dc_addr_i = '0; dc_wdata_i = '0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish (checks %0d)", checks);
        $fatal(1);
    end

    initial begin
        int  rv;
        int  cyc;
        logic done_seen;
        logic got_addr;
        logic [AW-1:0] first_addr;

        // Reset with busy-looking inputs: every output must still be zero
        rst = 1'b1;
        drive_idle();
        dc_wdata_i = 32'hFFFF_FFFF; mem_ready_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctl", 0, 32'(ctl_now()), 32'(C_IDLE));
        chk("rst_addr", 0, mem_addr_o, 32'h0);
        chk("rst_wdata", 0, mem_wdata_o, 32'h0);
        chk("rst_ic_rdata", 0, ic_rdata_o, 32'h0);
        chk("rst_dc_rdata", 0, dc_rdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();

        // IC-only refill at 0x1234, memory ready every 2nd cycle
        tbl.push_back(mk(0,1,32'h1234,0,0,0,0,0,0,32'h0,   C_IDLE));
        tbl.push_back(mk(0,1,32'h1234,0,0,0,0,0,0,32'h1230,C_ICW));
        tbl.push_back(mk(0,1,32'h1234,0,0,0,0,0,1,32'h1230,C_ICV));
        tbl.push_back(mk(0,1,32'h1234,0,0,0,0,0,0,32'h1234,C_ICW));
        tbl.push_back(mk(0,1,32'h1234,0,0,0,0,0,1,32'h1234,C_ICV));
        tbl.push_back(mk(0,1,32'h1234,0,0,0,0,0,0,32'h1238,C_ICW));
        tbl.push_back(mk(0,1,32'h1234,0,0,0,0,0,1,32'h1238,C_ICV));
        tbl.push_back(mk(0,1,32'h1234,0,0,0,0,0,0,32'h123C,C_ICW));
        tbl.push_back(mk(0,1,32'h1234,0,0,0,0,0,1,32'h123C,C_ICD));
        // Turnaround, then mem_ready in IDLE with no requests
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,32'h0,C_IDLE));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,32'h0,C_IDLE));
        // DC write-back at 0x2000, wdata A0..A3
        tbl.push_back(mk(0,0,0,0,1,1,32'h2000,32'hA0,0,32'h0,   C_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1,32'h2000,32'hA0,1,32'h2000,C_DWW));
        tbl.push_back(mk(0,0,0,0,1,1,32'h2000,32'hA1,1,32'h2004,C_DWW));
        tbl.push_back(mk(0,0,0,0,1,1,32'h2000,32'hA2,1,32'h2008,C_DWW));
        tbl.push_back(mk(0,0,0,0,1,1,32'h2000,32'hA3,1,32'h200C,C_DWD));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,C_IDLE));
        // Reset, then simultaneous requests: IC first, then DC
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,32'h0,C_IDLE));
        tbl.push_back(mk(0,1,32'h3000,0,1,0,32'h401C,0,0,32'h0,   C_IDLE));
        tbl.push_back(mk(0,1,32'h3000,0,1,0,32'h401C,0,1,32'h3000,C_ICV));
        tbl.push_back(mk(0,1,32'h3000,0,1,0,32'h401C,0,1,32'h3004,C_ICV));
        tbl.push_back(mk(0,1,32'h3000,0,1,0,32'h401C,0,1,32'h3008,C_ICV));
        tbl.push_back(mk(0,1,32'h3000,0,1,0,32'h401C,0,1,32'h300C,C_ICD));
        tbl.push_back(mk(0,0,0,0,1,0,32'h401C,0,1,32'h0,   C_IDLE));
        tbl.push_back(mk(0,0,0,0,1,0,32'h401C,0,1,32'h4010,C_DRV));
        tbl.push_back(mk(0,0,0,0,1,0,32'h401C,0,1,32'h4014,C_DRV));
        tbl.push_back(mk(0,0,0,0,1,0,32'h401C,0,1,32'h4018,C_DRV));
        tbl.push_back(mk(0,0,0,0,1,0,32'h401C,0,1,32'h401C,C_DRD));
        // Re-raise both: last owner was DC, so IC wins again
        tbl.push_back(mk(0,1,32'h5008,0,1,0,32'h6000,0,0,32'h0,   C_IDLE));
        tbl.push_back(mk(0,1,32'h5008,0,1,0,32'h6000,0,1,32'h5000,C_ICV));
        tbl.push_back(mk(0,1,32'h5008,0,1,0,32'h6000,0,1,32'h5004,C_ICV));
        tbl.push_back(mk(0,1,32'h5008,0,1,0,32'h6000,0,1,32'h5008,C_ICV));
        tbl.push_back(mk(0,1,32'h5008,0,1,0,32'h6000,0,1,32'h500C,C_ICD));
        tbl.push_back(mk(0,0,0,0,1,0,32'h6000,0,0,32'h0,   C_IDLE));
        tbl.push_back(mk(0,0,0,0,1,0,32'h6000,0,1,32'h6000,C_DRV));
        tbl.push_back(mk(0,0,0,0,1,0,32'h6000,0,1,32'h6004,C_DRV));
        tbl.push_back(mk(0,0,0,0,1,0,32'h6000,0,1,32'h6008,C_DRV));
        tbl.push_back(mk(0,0,0,0,1,0,32'h6000,0,1,32'h600C,C_DRD));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,C_IDLE));
        // IC abort after beat 1: beats 2-3 still run, silently
        tbl.push_back(mk(0,1,32'h7000,0,0,0,0,0,0,32'h0,   C_IDLE));
        tbl.push_back(mk(0,1,32'h7000,0,0,0,0,0,1,32'h7000,C_ICV));
        tbl.push_back(mk(0,1,32'h7000,0,0,0,0,0,1,32'h7004,C_ICV));
        tbl.push_back(mk(0,0,0,1,0,0,0,0,0,32'h7008,C_ICW));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,32'h7008,C_ICW));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,32'h700C,C_ICW));
        // Abort in IDLE blocks the grant for that cycle; then normal refill
        tbl.push_back(mk(0,1,32'h7100,1,0,0,0,0,0,32'h0,   C_IDLE));
        tbl.push_back(mk(0,1,32'h7100,0,0,0,0,0,0,32'h0,   C_IDLE));
        tbl.push_back(mk(0,1,32'h7100,0,0,0,0,0,1,32'h7100,C_ICV));
        tbl.push_back(mk(0,1,32'h7100,0,0,0,0,0,1,32'h7104,C_ICV));
        tbl.push_back(mk(0,1,32'h7100,0,0,0,0,0,1,32'h7108,C_ICV));
        tbl.push_back(mk(0,1,32'h7100,0,0,0,0,0,1,32'h710C,C_ICD));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,C_IDLE));
        // DC write at 0x8004, abort ignored, reset at beat 2, re-grant from beat 0
        tbl.push_back(mk(0,0,0,0,1,1,32'h8004,32'hB0,0,32'h0,   C_IDLE));
        tbl.push_back(mk(0,0,0,1,1,1,32'h8004,32'hB0,1,32'h8000,C_DWW));
        tbl.push_back(mk(0,0,0,0,1,1,32'h8004,32'hB1,1,32'h8004,C_DWW));
        tbl.push_back(mk(1,0,0,0,1,1,32'h8004,32'hB2,1,32'h0,   C_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1,32'h8004,32'hB0,0,32'h0,   C_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1,32'h8004,32'hB0,1,32'h8000,C_DWW));
        tbl.push_back(mk(0,0,0,0,1,1,32'h8004,32'hB1,1,32'h8004,C_DWW));
        tbl.push_back(mk(0,0,0,0,1,1,32'h8004,32'hB2,1,32'h8008,C_DWW));
        tbl.push_back(mk(0,0,0,0,1,1,32'h8004,32'hB3,1,32'h800C,C_DWD));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,32'h0,C_IDLE));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst         = tbl[i].rst;
            ic_req_i    = tbl[i].icr;
            ic_addr_i   = tbl[i].ica;
            ic_abort_i  = tbl[i].iab;
            dc_req_i    = tbl[i].dcr;
            dc_we_i     = tbl[i].dwe;
            dc_addr_i   = tbl[i].dca;
            dc_wdata_i  = tbl[i].dwd;
            mem_ready_i = tbl[i].rdy;
            mem_rdata_i = 32'hD000_0000 + 32'(i);
            #1;
            chk("ctl", i, 32'(ctl_now()), 32'(tbl[i].ectl));
            if (tbl[i].ectl[8] || tbl[i].rst)
                chk("mem_addr", i, mem_addr_o, tbl[i].eaddr);
            if (tbl[i].ectl[7])
                chk("mem_wdata", i, mem_wdata_o, tbl[i].dwd);
            if (tbl[i].rst)
                chk("rst_wdata", i, mem_wdata_o, 32'h0);
            if (tbl[i].ectl[5])
                chk("ic_rdata", i, ic_rdata_o, 32'hD000_0000 + 32'(i));
            if (tbl[i].ectl[1])
                chk("dc_rdata", i, dc_rdata_o, 32'hD000_0000 + 32'(i));
        end

        // Back-to-back ready, bounded wait for the line to complete
        @(negedge clk);
        drive_idle();
        ic_req_i = 1'b1; ic_addr_i = 32'h9ABC; mem_ready_i = 1'b1;
        #1;
        chk("seq_idle_ctl", 0, 32'(ctl_now()), 32'(C_IDLE));
        rv = 0; done_seen = 1'b0; got_addr = 1'b0; first_addr = '0;
        for (cyc = 0; cyc < 20 && !done_seen; cyc++) begin
            @(negedge clk);
            #1;
            if (mem_req_o && !got_addr) begin
                first_addr = mem_addr_o;
                got_addr   = 1'b1;
            end
            if (ic_rvalid_o) rv++;
            if (ic_done_o) done_seen = 1'b1;
        end
        chk("seq_done_seen", 0, 32'(done_seen), 32'h1);
        chk("seq_rvalid_cnt", 0, 32'(rv), 32'h4);
        chk("seq_first_addr", 0, first_addr, 32'h9AB0);
        @(negedge clk);
        ic_req_i = 1'b0;
        #1;
        chk("seq_turnaround_req", 0, 32'(mem_req_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single instruction/data memory port between Icache line refills and Dcache refills/write-backs.
- Sequences each line as a burst of single-word memory handshakes and steers read data back to the owner.
- Lets the fetch side abandon a refill on a taken jump/branch without corrupting the memory transaction.
- Sits between Icache, Dcache and the memory model. Flow control keeps using the Icache ready/hit signals unchanged.

Parameters:
- LINE_WORDS, 4, words per cache line. Must be a power of 2, at least 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ic_req_i  in  1  Icache refill request; held until ic_done_o or abort
- ic_addr_i  in  ADDR_W  Icache miss address (any byte in the line)
- ic_abort_i  in  1  fetch redirect; abandon the current/pending Icache refill
- ic_gnt_o  out  1  level; burst currently owned by Icache
- ic_rdata_o  out  32  refill word
- ic_rvalid_o  out  1  ic_rdata_o valid (one cycle per beat)
- ic_done_o  out  1  one-cycle pulse; line complete
- dc_req_i  in  1  Dcache request; held until dc_done_o
- dc_we_i  in  1  1 = write-back burst, 0 = refill
- dc_addr_i  in  ADDR_W  Dcache line address
- dc_wdata_i  in  32  write-back word for the current beat
- dc_gnt_o  out  1  level; burst currently owned by Dcache
- dc_wnext_o  out  1  pulse; current write word accepted, present the next one
- dc_rdata_o  out  32  refill word
- dc_rvalid_o  out  1  dc_rdata_o valid
- dc_done_o  out  1  one-cycle pulse; burst complete
- mem_req_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_W  word address of the current beat
- mem_wdata_o  out  32  write data (equals dc_wdata_i during a DC write)
- mem_rdata_i  in  32  read data, valid when mem_ready_i = 1
- mem_ready_i  in  1  one-cycle beat completion

Behaviour:
- Reset (async, any time including mid-burst):
  - state = IDLE, beat = 0, drop = 0, last_owner = DC.
  - All outputs 0; mem_req_o drops immediately.
  - No done pulse is issued for the interrupted burst.
- FSM states: IDLE, IC_BURST, DC_BURST.
- IDLE:
  - Candidates: ic_req_i && !ic_abort_i, and dc_req_i.
  - Both candidates present: the one not in last_owner wins (round-robin). After reset, IC therefore wins the first tie.
  - Winner's request is latched at the edge: base = addr with its low log2(LINE_WORDS)+2 bits cleared; we = dc_we_i for DC, 0 for IC.
  - gnt_o and mem_req_o go high the next cycle, so request-to-first-mem_req latency is 1 cycle.
- BURST:
  - mem_req_o = 1; mem_addr_o = base + beat*4; mem_we_o = latched we.
  - A beat completes in a cycle with mem_ready_i = 1.
  - Read beat: owner rdata_o = mem_rdata_i and rvalid_o = 1 in that same cycle (combinational from mem_ready_i, qualified by state).
  - Write beat: dc_wnext_o = 1 in that same cycle.
  - beat increments modulo LINE_WORDS.
- Last beat (beat = LINE_WORDS-1 with mem_ready_i = 1):
  - Owner done_o pulses that cycle; last_owner is updated.
  - Next state is IDLE. This gives one mandatory turnaround cycle with mem_req_o = 0 between bursts.
- IC abort:
  - ic_abort_i in any IC_BURST cycle sets drop.
  - Remaining beats still run to completion; the memory transaction is never cut short.
  - While drop = 1, ic_rvalid_o and ic_done_o are forced 0. drop clears on return to IDLE.
  - ic_abort_i in IDLE suppresses an IC grant in that cycle only.
  - ic_abort_i has no effect on a DC burst.
- Requester dropping its req mid-burst is ignored; the burst completes.
- A new request arriving during a burst waits in IDLE arbitration.
- mem_ready_i while in IDLE is ignored; nothing is emitted.
- Width rules:
  - beat is log2(LINE_WORDS) bits.
  - Address arithmetic is in ADDR_W bits; the low 2 bits of mem_addr_o are always 0.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, IC_BURST=1, DC_BURST=2)
  - owner enum (OWN_IC, OWN_DC)
  - localparam for line offset bits, clog2(LINE_WORDS)+2
- One natural sub-module: mem_burst_seq. It owns the beat counter, address generation and the last-beat flag.
- The arbiter keeps the FSM, round-robin, drop flag and response steering.

Test Plan:
- IC only, ic_addr_i=0x0000_1234, memory ready every 2nd cycle:
  - mem_addr_o = 0x1230, 0x1234, 0x1238, 0x123C.
  - 4 ic_rvalid_o pulses carrying mem_rdata_i; ic_done_o on the 4th.
  - mem_req_o low for 1 cycle afterwards.
- DC write-back at 0x0000_2000 with wdata per beat 0xA0..0xA3:
  - mem_we_o = 1 and mem_wdata_o follows dc_wdata_i.
  - 4 dc_wnext_o pulses; dc_done_o on the last; no dc_rvalid_o.
- ic_req_i and dc_req_i rise in the same cycle after reset, both held:
  - IC burst first, then DC.
  - Re-raise both together again: IC wins the tie (last_owner = DC).
- ic_abort_i pulsed after beat 1 of an IC refill:
  - Beats 2–3 still appear on the memory port.
  - ic_rvalid_o and ic_done_o stay 0; FSM returns to IDLE; the next IC request is granted normally.
- rst asserted mid DC burst at beat 2:
  - mem_req_o, dc_gnt_o and dc_done_o drop to 0 immediately.
  - After release, dc_req_i still high is re-granted from beat 0 at the base address.
- mem_ready_i pulsed in IDLE with no requests:
  - No rvalid/done/wnext outputs; the next request still starts at beat 0.
